// File: rtl/wb_port_arbiter.sv
// Writeback write-port arbiter: picks between execute and load-return, registers the write, tracks pending loads.
// Optional starvation guard for the execute path is enabled by defining WB_STARVE_GUARD_EN.
module wb_port_arbiter #(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic        i_clk,
   input  logic        i_rstn,
   input  logic        i_ex_valid,
   output logic        o_ex_ready,
   input  logic [4:0]  i_ex_rd,
   input  logic [31:0] i_ex_data,
   input  logic        i_mem_valid,
   output logic        o_mem_ready,
   input  logic [4:0]  i_mem_rd,
   input  logic [31:0] i_mem_data,
   input  logic        i_issue_valid,
   input  logic [4:0]  i_issue_rd,
   output logic        o_write_enable,
   output logic [4:0]  o_write_addr,
   output logic [31:0] o_write_data,
   output logic [31:0] o_busy
);

   localparam int unsigned REG_W  = 5;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned NREG   = 32;
   localparam int unsigned CNT_W  = 4;

   logic              w_starved;
   logic              w_ex_grant;
   logic              w_mem_grant;
   logic              w_grant_any;
   logic [REG_W-1:0]  w_win_rd;
   logic [DATA_W-1:0] w_win_data;
   logic [NREG-1:0]   w_busy_set;
   logic [NREG-1:0]   w_busy_clr;
   logic [NREG-1:0]   w_busy_nxt;

   logic              r_write_enable;
   logic [REG_W-1:0]  r_write_addr;
   logic [DATA_W-1:0] r_write_data;
   logic [NREG-1:0]   r_busy;

`ifdef WB_STARVE_GUARD_EN
   localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

   logic [CNT_W-1:0] r_starve_cnt;

   // Counts cycles the execute path has been waiting; saturates at the limit.
   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_starve_cnt <= '0;
      end else if (!i_ex_valid || w_ex_grant) begin
         r_starve_cnt <= '0;
      end else if (r_starve_cnt != STARVE_MAX) begin
         r_starve_cnt <= r_starve_cnt + CNT_W'(1);
      end
   end

   assign w_starved = (r_starve_cnt == STARVE_MAX);
`else
   logic [CNT_W-1:0] w_unused_limit;
   assign w_unused_limit = CNT_W'(STARVE_LIMIT);
   assign w_starved      = 1'b0;
`endif

   // Load return has priority unless execute has starved; nothing is granted in reset.
   always_comb begin
      w_mem_grant = i_rstn & i_mem_valid & ~(i_ex_valid & w_starved);
      w_ex_grant  = i_rstn & i_ex_valid & ~w_mem_grant;
      w_grant_any = w_mem_grant | w_ex_grant;
      w_win_rd    = w_mem_grant ? i_mem_rd   : i_ex_rd;
      w_win_data  = w_mem_grant ? i_mem_data : i_ex_data;
   end

   // Scoreboard update: set on issue, clear on load return; set wins on the same bit.
   always_comb begin
      w_busy_set = '0;
      w_busy_clr = '0;
      if (i_issue_valid && (i_issue_rd != '0)) begin
         w_busy_set[i_issue_rd] = 1'b1;
      end
      if (w_mem_grant && (i_mem_rd != '0)) begin
         w_busy_clr[i_mem_rd] = 1'b1;
      end
      w_busy_nxt    = (r_busy & ~w_busy_clr) | w_busy_set;
      w_busy_nxt[0] = 1'b0;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rstn) begin
         r_write_enable <= 1'b0;
         r_write_addr   <= '0;
         r_write_data   <= '0;
         r_busy         <= '0;
      end else begin
         r_write_enable <= w_grant_any && (w_win_rd != '0);
         if (w_grant_any) begin
            r_write_addr <= w_win_rd;
            r_write_data <= w_win_data;
         end
         r_busy <= w_busy_nxt;
      end
   end

   assign o_ex_ready     = w_ex_grant;
   assign o_mem_ready    = w_mem_grant;
   assign o_write_enable = r_write_enable;
   assign o_write_addr   = r_write_addr;
   assign o_write_data   = r_write_data;
   assign o_busy         = r_busy;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: vector table plus contention and mid-run reset sequences.
module tb_wb_port_arbiter;

   logic        clk = 1'b0;
   logic        rstn;
   logic        ex_valid, mem_valid, issue_valid;
   logic [4:0]  ex_rd, mem_rd, issue_rd;
   logic [31:0] ex_data, mem_data;
   logic        ex_ready, mem_ready, write_enable;
   logic [4:0]  write_addr;
   logic [31:0] write_data, busy;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wb_port_arbiter #(.STARVE_LIMIT(4)) dut (
      .i_clk(clk), .i_rstn(rstn),
      .i_ex_valid(ex_valid), .o_ex_ready(ex_ready), .i_ex_rd(ex_rd), .i_ex_data(ex_data),
      .i_mem_valid(mem_valid), .o_mem_ready(mem_ready), .i_mem_rd(mem_rd), .i_mem_data(mem_data),
      .i_issue_valid(issue_valid), .i_issue_rd(issue_rd),
      .o_write_enable(write_enable), .o_write_addr(write_addr), .o_write_data(write_data),
      .o_busy(busy)
   );

   typedef struct {
      logic        exv;  logic [4:0] exrd;  logic [31:0] exd;
      logic        memv; logic [4:0] memrd; logic [31:0] memd;
      logic        issv; logic [4:0] issrd;
      logic        e_exr; logic e_memr; logic e_we;
      logic [4:0]  e_addr; logic [31:0] e_data; logic [31:0] e_busy;
   } vec_t;

   vec_t vecs[10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic exv, input logic [4:0] exrd, input logic [31:0] exd,
                        input logic memv, input logic [4:0] memrd, input logic [31:0] memd,
                        input logic issv, input logic [4:0] issrd);
      ex_valid = exv;  ex_rd = exrd;  ex_data = exd;
      mem_valid = memv; mem_rd = memrd; mem_data = memd;
      issue_valid = issv; issue_rd = issrd;
   endtask

   initial begin
      vecs[0] = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                  1'b1, 1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 32'h0};
      vecs[1] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                  1'b0, 1'b0, 1'b0, 5'd5, 32'hDEADBEEF, 32'h0};
      vecs[2] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0,
                  1'b0, 1'b1, 1'b0, 5'd0, 32'h11111111, 32'h0};
      vecs[3] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                  1'b0, 1'b0, 1'b0, 5'd0, 32'h11111111, 32'h00000080};
      vecs[4] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'hA5A5A5A5, 1'b1, 5'd9,
                  1'b0, 1'b1, 1'b1, 5'd7, 32'hA5A5A5A5, 32'h00000200};
      vecs[5] = '{1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h00000077, 1'b1, 5'd7,
                  1'b0, 1'b1, 1'b1, 5'd7, 32'h00000077, 32'h00000280};
      vecs[6] = '{1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                  1'b0, 1'b0, 1'b0, 5'd7, 32'h00000077, 32'h00000280};
      vecs[7] = '{1'b1, 5'd3, 32'h00000003, 1'b1, 5'd9, 32'h00000009, 1'b0, 5'd0,
                  1'b0, 1'b1, 1'b1, 5'd9, 32'h00000009, 32'h00000080};
      vecs[8] = '{1'b1, 5'd3, 32'h00000003, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                  1'b1, 1'b0, 1'b1, 5'd3, 32'h00000003, 32'h00000080};
      vecs[9] = '{1'b1, 5'd0, 32'hCAFE0000, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                  1'b1, 1'b0, 1'b0, 5'd0, 32'hCAFE0000, 32'h00000080};

      // Reset with both requesters offering
      rstn = 1'b0;
      drive(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd4);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk); #1;
         check("reset_ex_ready", 32'(ex_ready), 32'd0);
         check("reset_mem_ready", 32'(mem_ready), 32'd0);
      end
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      check("reset_we", 32'(write_enable), 32'd0);
      check("reset_busy", busy, 32'd0);
      check("reset_addr", 32'(write_addr), 32'd0);
      check("reset_data", write_data, 32'd0);

      // Table-driven single-cycle vectors
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].exv, vecs[i].exrd, vecs[i].exd, vecs[i].memv, vecs[i].memrd,
               vecs[i].memd, vecs[i].issv, vecs[i].issrd);
         #1;
         check($sformatf("v%0d_ex_ready", i), 32'(ex_ready), 32'(vecs[i].e_exr));
         check($sformatf("v%0d_mem_ready", i), 32'(mem_ready), 32'(vecs[i].e_memr));
         @(posedge clk); #1;
         check($sformatf("v%0d_we", i), 32'(write_enable), 32'(vecs[i].e_we));
         check($sformatf("v%0d_addr", i), 32'(write_addr), 32'(vecs[i].e_addr));
         check($sformatf("v%0d_data", i), write_data, vecs[i].e_data);
         check($sformatf("v%0d_busy", i), busy, vecs[i].e_busy);
         @(negedge clk);
      end
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      @(posedge clk); #1;
      check("single_ex_we_drop", 32'(write_enable), 32'd0);
      @(negedge clk);

      // Continuous contention: execute wins only on the fifth cycle when the guard is built in
      for (int i = 0; i < 6; i++) begin
         logic exp_ex;
`ifdef WB_STARVE_GUARD_EN
         exp_ex = (i == 4);
`else
         exp_ex = 1'b0;
`endif
         drive(1'b1, 5'd2, 32'h000000E0, 1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 5'd0);
         #1;
         check($sformatf("cont%0d_ex_ready", i), 32'(ex_ready), 32'(exp_ex));
         check($sformatf("cont%0d_mem_ready", i), 32'(mem_ready), 32'(!exp_ex));
         @(posedge clk); #1;
         check($sformatf("cont%0d_we", i), 32'(write_enable), 32'd1);
         check($sformatf("cont%0d_addr", i), 32'(write_addr), exp_ex ? 32'd2 : 32'(10 + i));
         check($sformatf("cont%0d_data", i), write_data, exp_ex ? 32'hE0 : 32'h100 + 32'(i));
         @(negedge clk);
      end

      // Mid-run reset drops the offered transfer and clears the scoreboard
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd12);
      @(posedge clk); #1;
      check("pre_reset_busy", busy, 32'h00001080);
      @(negedge clk);
      rstn = 1'b0;
      drive(1'b1, 5'd6, 32'h66, 1'b1, 5'd12, 32'hCC, 1'b1, 5'd13);
      #1;
      check("midreset_ex_ready", 32'(ex_ready), 32'd0);
      check("midreset_mem_ready", 32'(mem_ready), 32'd0);
      @(posedge clk); #1;
      check("midreset_we", 32'(write_enable), 32'd0);
      check("midreset_busy", busy, 32'd0);
      check("midreset_addr", 32'(write_addr), 32'd0);
      @(negedge clk);
      rstn = 1'b1;
      drive(1'b1, 5'd4, 32'h44444444, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      #1;
      check("first_grant_ex_ready", 32'(ex_ready), 32'd1);
      @(posedge clk); #1;
      check("first_grant_we", 32'(write_enable), 32'd1);
      check("first_grant_addr", 32'(write_addr), 32'd4);
      check("first_grant_data", write_data, 32'h44444444);
      @(negedge clk);
      drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
      @(posedge clk); #1;
      check("first_grant_we_drop", 32'(write_enable), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
